regfile_display_scanner: RTL

Reads the register file's six general registers and the PC once per VGA frame and writes them as ASCII text into the character buffer that the VGA text renderer displays. It is the consumer end of the register file's read-port interface: it drives a read address, samples the read data, and emits hex characters over a write handshake to the character RAM. A scan starts on each frame-start pulse from the VGA timing block.

---
 rtl/regfile_display_scanner_pkg.sv | 24 ++
 rtl/regfile_display_scanner_if.sv | 24 ++
 rtl/regfile_display_scanner_hex_to_ascii.sv | 18 +
 rtl/regfile_display_scanner.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/regfile_display_scanner_pkg.sv
// Shared types and constants for the register display scanner.
// FSM states, ASCII glyph codes and row geometry.
package regfile_display_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EMIT,
    ST_NEXT
  } state_t;

  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_P  = 8'h50;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  localparam int NUM_REGS_DEF = 6;
  localparam int PC_ROW       = NUM_REGS_DEF;

  localparam logic [2:0] LAST_COL = 3'd6;

endpackage

// File: rtl/regfile_display_scanner_if.sv
// Character-buffer write handshake.
// master drives char_we/char_addr/char_data, slave drives char_ready.
interface regfile_display_scanner_if #(
  parameter int ADDR_W = 8
);
  logic              char_we;
  logic [ADDR_W-1:0] char_addr;
  logic [7:0]        char_data;
  logic              char_ready;

  modport master (
    output char_we,
    output char_addr,
    output char_data,
    input  char_ready
  );

  modport slave (
    input  char_we,
    input  char_addr,
    input  char_data,
    output char_ready
  );
endinterface

// File: rtl/regfile_display_scanner_hex_to_ascii.sv
// Nibble to upper-case ASCII hex digit, purely combinational.
// Ports: i_nib (4b nibble), o_ascii (8b character).
module hex_to_ascii
  import regfile_display_scanner_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nib < 4'd10) begin
      o_ascii = ASCII_0 + {4'h0, i_nib};
    end else begin
      o_ascii = ASCII_A + {4'h0, i_nib} - 8'd10;
    end
  end

endmodule

// File: rtl/regfile_display_scanner.sv
// Per-frame dump of general registers and PC as hex text rows.
// Ports: clk/rst, frame_start, rd_addr/rd_data/pc_value, char_bus (master), busy/done.
module regfile_display_scanner
  import regfile_display_scanner_pkg::*;
#(
  parameter int NUM_REGS   = NUM_REGS_DEF,
  parameter int ROW_STRIDE = 8,
  parameter int BASE_ADDR  = 0,
  parameter int ADDR_W     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_start,
  output logic [5:0]                 rd_addr,
  input  logic [15:0]                rd_data,
  input  logic [15:0]                pc_value,
  regfile_display_scanner_if.master  char_bus,
  output logic                       busy,
  output logic                       done
);

  localparam int ROW_W = $clog2(NUM_REGS + 1);
  localparam logic [ROW_W-1:0] PC_ROW_L = ROW_W'(NUM_REGS);

  state_t           r_state;
  state_t           w_next;
  logic [ROW_W-1:0] r_row;
  logic [2:0]       r_col;
  logic [15:0]      r_snap;
  logic [5:0]       r_rd_addr;
  logic             r_done;

  logic             w_pc_row;
  logic             w_emit;
  logic             w_fire;
  logic [3:0]       w_nib;
  logic [7:0]       w_hex;
  logic [7:0]       w_char;
  logic [ADDR_W-1:0] w_addr;

  assign w_pc_row = (r_row == PC_ROW_L);
  // rst gates the request so nothing is written while reset is held
  assign w_emit   = (r_state == ST_EMIT) && !rst;
  assign w_fire   = w_emit && char_bus.char_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        // a start coinciding with done is dropped
        if (frame_start && !r_done) begin
          w_next = ST_FETCH;
        end
      end
      ST_FETCH: w_next = ST_EMIT;
      ST_EMIT: begin
        if (w_fire && (r_col == LAST_COL)) begin
          w_next = ST_NEXT;
        end
      end
      ST_NEXT: w_next = w_pc_row ? ST_IDLE : ST_FETCH;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row     <= '0;
      r_col     <= '0;
      r_snap    <= '0;
      r_rd_addr <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == ST_NEXT) && w_pc_row;
      unique case (r_state)
        ST_IDLE: begin
          if (w_next == ST_FETCH) begin
            r_row <= '0;
          end
        end
        ST_FETCH: begin
          r_col  <= '0;
          r_snap <= w_pc_row ? pc_value : rd_data;
          if (!w_pc_row) begin
            r_rd_addr <= 6'(r_row);
          end
        end
        ST_EMIT: begin
          if (w_fire) begin
            r_col <= r_col + 3'd1;
          end
        end
        ST_NEXT: begin
          if (!w_pc_row) begin
            r_row <= r_row + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // read address tracks the row only while fetching a register row
  assign rd_addr = ((r_state == ST_FETCH) && !w_pc_row)
                 ? 6'(r_row) : r_rd_addr;

  always_comb begin
    w_nib = r_snap[3:0];
    case (r_col)
      3'd3:    w_nib = r_snap[15:12];
      3'd4:    w_nib = r_snap[11:8];
      3'd5:    w_nib = r_snap[7:4];
      default: w_nib = r_snap[3:0];
    endcase
  end

  hex_to_ascii u_hex (
    .i_nib   (w_nib),
    .o_ascii (w_hex)
  );

  always_comb begin
    w_char = 8'h00;
    case (r_col)
      3'd0:    w_char = w_pc_row ? ASCII_P : ASCII_R;
      3'd1:    w_char = w_pc_row ? ASCII_C : ASCII_0 + 8'(r_row);
      3'd2:    w_char = ASCII_EQ;
      3'd3,
      3'd4,
      3'd5,
      3'd6:    w_char = w_hex;
      default: w_char = 8'h00;
    endcase
  end

  assign w_addr = ADDR_W'(BASE_ADDR)
                + ADDR_W'(r_row) * ADDR_W'(ROW_STRIDE)
                + ADDR_W'(r_col);

  assign char_bus.char_we   = w_emit;
  assign char_bus.char_addr = w_emit ? w_addr : '0;
  assign char_bus.char_data = w_emit ? w_char : 8'h00;

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;

endmodule
